// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with bounded burst lock in front of the async FIFO write side.
// Optional stall counter is built when ARB_STALL_CNT_EN is defined.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ*DATA_WIDTH-1:0] WDATA,
  output logic [N_REQ-1:0]            GNT,
  input  logic                        FULL,
  output logic                        W_INC,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic                        BUSY,
  output logic [15:0]                 STALL_CNT
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]   sel, gidx;
  logic [IW:0]     idx;
  logic            found;
  logic [N_REQ-1:0] gnt;
  logic            w_inc;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping at N_REQ (not at 2**IW).
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (!found && REQ[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    w_inc       = 1'b0;
    gidx        = (state_q == BURST) ? owner_q : sel;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (found && !FULL) begin
            gnt[sel] = 1'b1;
            w_inc    = 1'b1;
            if (MAX_BURST == 1) begin
              rr_ptr_d = nxt(sel);
            end else begin
              state_d     = BURST;
              owner_d     = sel;
              burst_cnt_d = 8'd1;
            end
          end
        end
        BURST: begin
          if (REQ[owner_q]) begin
            if (!FULL) begin
              gnt[owner_q] = 1'b1;
              w_inc        = 1'b1;
              burst_cnt_d  = burst_cnt_q + 8'd1;
              if (burst_cnt_q + 8'd1 == 8'(MAX_BURST)) begin
                state_d     = IDLE;
                rr_ptr_d    = nxt(owner_q);
                burst_cnt_d = '0;
              end
            end
          end else begin
            // Owner went quiet: release now, re-arbitrate next cycle.
            state_d     = IDLE;
            rr_ptr_d    = nxt(owner_q);
            burst_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign GNT     = gnt;
  assign W_INC   = w_inc;
  assign WR_DATA = w_inc ? WDATA[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign BUSY    = !RST && (state_q == BURST);

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|REQ) && FULL && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign STALL_CNT = stall_cnt_q;
`else
  assign STALL_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench: two arbiters (N=4/burst 4 and N=5/burst 1) against a tenure-level model.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;

  typedef struct {
    logic [4:0]  gnt;
    logic        w_inc;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  req0, gnt0;
  logic [31:0] wd0;
  logic [4:0]  req1, gnt1;
  logic [39:0] wd1;
  logic        full0, full1, winc0, winc1, busy0, busy1;
  logic [7:0]  wr0, wr1;
  logic [15:0] st0, st1;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(4), .MAX_BURST(4)) u0 (
    .CLK(clk), .RST(rst), .REQ(req0), .WDATA(wd0), .GNT(gnt0), .FULL(full0),
    .W_INC(winc0), .WR_DATA(wr0), .BUSY(busy0), .STALL_CNT(st0));

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(5), .MAX_BURST(1)) u1 (
    .CLK(clk), .RST(rst), .REQ(req1), .WDATA(wd1), .GNT(gnt1), .FULL(full1),
    .W_INC(winc1), .WR_DATA(wr1), .BUSY(busy1), .STALL_CNT(st1));

  exp_t       sbq[2][$];
  logic [4:0] mreq[2];
  logic [7:0] mdat[2][5];
  logic       mfull[2];
  int holder[2], taken[2], ptr[2], stall_m[2], lastg[2];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: who holds the port, how many words this tenure, whose turn is next.
  task automatic step(input int u, input int n, input int mb);
    exp_t e;
    int g, s;
    g = -1;
    s = -1;
    e.gnt = '0; e.w_inc = 1'b0; e.data = '0;
    e.busy = !rst && (holder[u] >= 0);
`ifdef ARB_STALL_CNT_EN
    e.stall = 16'(stall_m[u]);
`else
    e.stall = 16'h0;
`endif
    if (rst) begin
      holder[u] = -1; taken[u] = 0; ptr[u] = 0; stall_m[u] = 0;
    end else begin
      if ((|mreq[u]) && mfull[u] && stall_m[u] < 65535) stall_m[u]++;
      if (holder[u] < 0) begin
        for (int k = 0; k < n; k++)
          if (s < 0 && mreq[u][(ptr[u] + k) % n]) s = (ptr[u] + k) % n;
        if (s >= 0 && !mfull[u]) begin
          g = s;
          if (mb == 1) ptr[u] = (s + 1) % n;
          else begin holder[u] = s; taken[u] = 1; end
        end
      end else if (mreq[u][holder[u]]) begin
        if (!mfull[u]) begin
          g = holder[u];
          taken[u]++;
          if (taken[u] == mb) begin ptr[u] = (holder[u] + 1) % n; holder[u] = -1; end
        end
      end else begin
        ptr[u] = (holder[u] + 1) % n;
        holder[u] = -1;
      end
    end
    if (g >= 0) begin
      e.gnt[g] = 1'b1;
      e.w_inc  = 1'b1;
      e.data   = mdat[u][g];
    end
    lastg[u] = g;
    sbq[u].push_back(e);
  endtask

  task automatic chk(input string nm, input int u, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s unit%0d t=%0t got %0h expected %0h", nm, u, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq[0].size() > 0) begin
      e = sbq[0].pop_front();
      chk("gnt",   0, 40'({1'b0, gnt0}), 40'(e.gnt));
      chk("w_inc", 0, 40'(winc0), 40'(e.w_inc));
      chk("data",  0, 40'(wr0),   40'(e.data));
      chk("busy",  0, 40'(busy0), 40'(e.busy));
      chk("stall", 0, 40'(st0),   40'(e.stall));
    end
    if (sbq[1].size() > 0) begin
      e = sbq[1].pop_front();
      chk("gnt",   1, 40'(gnt1),  40'(e.gnt));
      chk("w_inc", 1, 40'(winc1), 40'(e.w_inc));
      chk("data",  1, 40'(wr1),   40'(e.data));
      chk("busy",  1, 40'(busy1), 40'(e.busy));
      chk("stall", 1, 40'(st1),   40'(e.stall));
    end
  end

  initial begin
    int ncyc, pct, fpct, n;
    logic [4:0] mask;
`ifdef ARB_STALL_CNT_EN
    ncyc = 3000 + 66000;
`else
    ncyc = 3000;
`endif
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mreq[u] = '0; mfull[u] = 1'b0; lastg[u] = -1;
      holder[u] = -1; taken[u] = 0; ptr[u] = 0; stall_m[u] = 0;
      for (int i = 0; i < 5; i++) mdat[u][i] = '0;
    end
    req0 = '0; req1 = '0; wd0 = '0; wd1 = '0; full0 = 1'b0; full1 = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      rst  = (c < 2) || (c == 1500);
      mask = 5'b11111;
      if (c < 400)       begin pct = 100; fpct = 0;  end
      else if (c < 1500) begin pct = 60;  fpct = 20; end
      else if (c < 2500) begin pct = 30;  fpct = 50; end
      else if (c < 3000) begin pct = 100; fpct = 0; mask = 5'b00101; end
      else               begin pct = 100; fpct = 100; end
      for (int u = 0; u < 2; u++) begin
        n = (u == 0) ? 4 : 5;
        for (int i = 0; i < n; i++) begin
          if (!mask[i]) mreq[u][i] = 1'b0;
          else if (lastg[u] == i || !mreq[u][i]) begin
            mreq[u][i] = ($urandom_range(99) < pct);
            mdat[u][i] = 8'($urandom);
          end
        end
        mfull[u] = ($urandom_range(99) < fpct);
        step(u, n, (u == 0) ? 4 : 1);
      end
      req0 = mreq[0][3:0]; full0 = mfull[0];
      req1 = mreq[1];      full1 = mfull[1];
      for (int i = 0; i < 4; i++) wd0[i*DW +: DW] = mdat[0][i];
      for (int i = 0; i < 5; i++) wd1[i*DW +: DW] = mdat[1][i];
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
